// File: rtl/weight_stream_pkg.sv
// -----------------------------------------------------------------------------
// weight_stream_pkg
// Shared types for the weight ROM stream controller.
//   state_t : controller FSM states (IDLE, RUN, DRAIN)
//   tag_t   : per-read tracker tag travelling alongside the ROM pipeline
//             {valid: a real read was issued, last: read was address DEPTH-1}
// -----------------------------------------------------------------------------
package weight_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

endpackage

// File: rtl/weight_stream_fifo.sv
// -----------------------------------------------------------------------------
// weight_stream_fifo
// Show-ahead FIFO: the head entry is visible on head_data whenever head_valid
// is high; pop consumes it. Push and pop in the same cycle keep count unchanged.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           synchronous flush (empties the FIFO)
//   push, push_data write one entry
//   pop             consume the head entry (only legal when head_valid)
//   head_data       current head entry
//   head_valid      FIFO not empty
//   count           number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module weight_stream_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking (=) here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // Upstream credit accounting must never let these fire.
         assert (!(push && !pop && (count == CW'(DEPTH))));
         assert (!(pop && (count == '0)));
      end
   end

   // NOTE: the storage array is deliberately not reset; only pointers and count
   // are, so it maps onto plain RAM/flop arrays without reset wiring.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head_data  = mem[rd_ptr];
   assign head_valid = (count != '0);

endmodule

// File: rtl/weight_rom_stream_ctrl.sv
// -----------------------------------------------------------------------------
// weight_rom_stream_ctrl
// Sequences reads from a registered weight ROM (ROM_LATENCY cycles, ce-gated)
// and presents the words as a valid/ready stream. Addresses are issued only
// when the output FIFO is guaranteed room (stored + in-flight < FIFO_DEPTH), so
// the stream can stall arbitrarily without losing ROM data. A job makes
// max(num_passes,1) passes over addresses 0..DEPTH-1.
// Ports:
//   clk, rst        clock, synchronous active-high reset (aborts any job)
//   start           begin a job (sampled only in IDLE)
//   num_passes      pass count, latched on start (0 behaves as 1)
//   abort           (only with WEIGHT_STREAM_ABORT_EN) cancel job, no done
//   busy            job in progress (RUN or DRAIN)
//   done            one-cycle pulse after the final beat is accepted
//   rom_addr/rom_ce ROM read address and pipeline enable
//   rom_q           ROM read data
//   data_out*       show-ahead output stream (data, last-of-pass, valid)
//   data_out_ready  downstream ready
// Build option: define WEIGHT_STREAM_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module weight_rom_stream_ctrl
   import weight_stream_pkg::*;
#(
   parameter int DEPTH       = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
   parameter int ROM_LATENCY = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int PASS_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [PASS_WIDTH-1:0] num_passes,
`ifdef WEIGHT_STREAM_ABORT_EN
   input  logic                  abort,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic                  rom_ce,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_last,
   output logic                  data_out_valid,
   input  logic                  data_out_ready
);

   localparam int ICW = $clog2(ROM_LATENCY + 1);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [PASS_WIDTH-1:0]   pass_cnt;
   logic [PASS_WIDTH-1:0]   passes;
   tag_t                    tag_sr [ROM_LATENCY];
   tag_t                    tail;
   logic [ICW-1:0]          inflight_count;
   logic [FCW-1:0]          fifo_count;
   logic [DATA_WIDTH:0]     head_data;
   logic                    head_valid;
   logic                    issue;
   logic                    addr_at_end;
   logic                    push;
   logic                    pop;
   logic                    flush;
   logic                    drain_clear;
   int                      fifo_next;
   int                      inflight_next;

`ifdef WEIGHT_STREAM_ABORT_EN
   assign flush = abort && busy;
`else
   assign flush = 1'b0;
`endif

   assign tail        = tag_sr[ROM_LATENCY-1];
   assign addr_at_end = (addr == ADDR_WIDTH'(DEPTH - 1));
   assign push        = busy && tail.valid;
   assign pop         = head_valid && data_out_ready;

   // NOTE: every always_comb output gets a default before any conditional
   // logic, so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      inflight_count = '0;
      for (int i = 0; i < ROM_LATENCY; i++)
         inflight_count = inflight_count + ICW'(tag_sr[i].valid);
      // Registered counts only: a pop in this cycle earns no credit yet.
      issue = (state == ST_RUN) &&
              ((int'(fifo_count) + int'(inflight_count)) < FIFO_DEPTH);
      // Look one cycle ahead so done can be a registered pulse.
      fifo_next     = int'(fifo_count) + int'(push) - int'(pop);
      inflight_next = int'(inflight_count) - int'(tail.valid);
      drain_clear   = (fifo_next == 0) && (inflight_next == 0);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         addr     <= '0;
         pass_cnt <= '0;
         passes   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_RUN;
                  busy     <= 1'b1;
                  addr     <= '0;
                  pass_cnt <= '0;
                  passes   <= (num_passes == '0) ? PASS_WIDTH'(1) : num_passes;
               end
            end
            ST_RUN: begin
               if (issue) begin
                  if (addr_at_end) begin
                     addr     <= '0;
                     pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                     if (pass_cnt == passes - PASS_WIDTH'(1)) state <= ST_DRAIN;
                  end else begin
                     addr <= addr + ADDR_WIDTH'(1);
                  end
               end
            end
            ST_DRAIN: begin
               // done is raised one cycle early; the DRAIN cycle carrying it
               // is the last busy cycle.
               if (done) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else if (drain_clear) begin
                  done <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Tag shift register mirrors the ROM pipeline; it only moves when ce is high.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < ROM_LATENCY; i++) tag_sr[i] <= '{valid: 1'b0, last: 1'b0};
      end else if (busy) begin
         tag_sr[0] <= '{valid: issue, last: addr_at_end};
         for (int i = 1; i < ROM_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
      end
   end

   weight_stream_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear      (flush),
      .push       (push),
      .push_data  ({tail.last, rom_q}),
      .pop        (pop),
      .head_data  (head_data),
      .head_valid (head_valid),
      .count      (fifo_count)
   );

   assign rom_addr       = addr;
   assign rom_ce         = busy;
   assign data_out_valid = head_valid;
   assign data_out       = head_valid ? head_data[DATA_WIDTH-1:0] : '0;
   assign data_out_last  = head_valid && head_data[DATA_WIDTH];

endmodule

// File: tb/tb_weight_rom_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_rom_stream_ctrl
// Self-checking bench for weight_rom_stream_ctrl with DEPTH=4 and a ROM model
// holding 0x1000+i. Expected beats come from a queue built from the pass/address
// rules; cycle-exact busy/valid/done checks apply when ready is held high.
// Build option: WEIGHT_STREAM_ABORT_EN adds the abort scenario.
// -----------------------------------------------------------------------------
module tb_weight_rom_stream_ctrl;
   localparam int DEPTH = 4;
   localparam int DW    = 16;
   localparam int AW    = $clog2(DEPTH) + 1;
   localparam int PW    = 16;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [PW-1:0] num_passes;
   logic          busy;
   logic          done;
   logic [AW-1:0] rom_addr;
   logic          rom_ce;
   logic [DW-1:0] rom_q;
   logic [DW-1:0] rom_s1;
   logic [DW-1:0] data_out;
   logic          data_out_last;
   logic          data_out_valid;
   logic          data_out_ready;
`ifdef WEIGHT_STREAM_ABORT_EN
   logic          abort;
`endif

   int    tests = 0;
   int    fails = 0;
   beat_t exp_q[$];

   always #5 clk = ~clk;

   weight_rom_stream_ctrl #(
      .DEPTH       (DEPTH),
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .ROM_LATENCY (2),
      .FIFO_DEPTH  (4),
      .PASS_WIDTH  (PW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .num_passes     (num_passes),
`ifdef WEIGHT_STREAM_ABORT_EN
      .abort          (abort),
`endif
      .busy           (busy),
      .done           (done),
      .rom_addr       (rom_addr),
      .rom_ce         (rom_ce),
      .rom_q          (rom_q),
      .data_out       (data_out),
      .data_out_last  (data_out_last),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready)
   );

   // Two-stage registered ROM, both stages gated by ce.
   always @(posedge clk) begin
      if (rom_ce) begin
         rom_s1 <= DW'(32'h1000) + DW'(rom_addr);
         rom_q  <= rom_s1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: ready always high (cycle-exact checks), 1: random ready,
   // 2: ready low for the first 20 cycles. extra_start re-pulses start.
   task automatic run_job(input int np, input int mode, input int extra_start);
      int            n;
      int            dones;
      logic          stalled;
      logic [DW-1:0] pd;
      logic          pl;
      beat_t         e;
      n = ((np == 0) ? 1 : np) * DEPTH;
      exp_q.delete();
      for (int p = 0; p < ((np == 0) ? 1 : np); p++)
         for (int i = 0; i < DEPTH; i++)
            exp_q.push_back('{data: DW'(32'h1000 + i), last: (i == DEPTH - 1)});
      num_passes = PW'(np);
      dones      = 0;
      stalled    = 1'b0;
      pd         = '0;
      pl         = 1'b0;
      for (int k = 0; k < 600; k++) begin
         start = (k == 0) || (k == extra_start);
         case (mode)
            0:       data_out_ready = 1'b1;
            1:       data_out_ready = 1'($urandom_range(0, 1));
            default: data_out_ready = (k >= 20);
         endcase
         @(negedge clk);
         if (mode == 0) begin
            check("busy_timing",  busy,           (k >= 1) && (k <= n + 4));
            check("valid_timing", data_out_valid, (k >= 4) && (k < n + 4));
            check("done_timing",  done,           k == n + 4);
         end
         if (mode == 1) check("fifo_bound", dut.u_fifo.count <= 3'd4, 1);
         if (mode == 2 && k == 19) begin
            check("stall_fifo_full", dut.u_fifo.count, 4);
            check("stall_inflight",  dut.inflight_count, 0);
            check("stall_no_issue",  dut.issue, 0);
         end
         if (stalled) begin
            check("stall_valid", data_out_valid, 1);
            check("stall_data",  data_out, pd);
            check("stall_last",  data_out_last, pl);
         end
         if (data_out_valid && data_out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", data_out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", data_out, e.data);
               check("beat_last", data_out_last, e.last);
            end
         end
         stalled = data_out_valid && !data_out_ready;
         pd      = data_out;
         pl      = data_out_last;
         if (done) dones++;
         @(posedge clk);
         #1;
         if (dones > 0) break;
      end
      start = 1'b0;
      data_out_ready = 1'b1;
      check("beats_left", exp_q.size(), 0);
      check("done_count", dones, 1);
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         check("idle_busy",  busy, 0);
         check("idle_valid", data_out_valid, 0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int acc;
      rst = 1'b1;
      start = 1'b0;
      num_passes = '0;
      data_out_ready = 1'b0;
`ifdef WEIGHT_STREAM_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_busy",  busy, 0);
      check("rst_done",  done, 0);
      check("rst_valid", data_out_valid, 0);
      check("rst_last",  data_out_last, 0);
      check("rst_ce",    rom_ce, 0);
      check("rst_addr",  rom_addr, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_job(1, 0, -1);   // single pass, exact latency and done timing
      run_job(3, 0, -1);   // three passes, no bubbles, last every 4th beat
      run_job(2, 1, -1);   // random backpressure
      run_job(2, 2, -1);   // long stall fills FIFO then drains in order
      run_job(0, 0, 6);    // zero passes acts as one; mid-job start ignored
      run_job(0, 0, 8);    // start in the done cycle ignored

      // Synchronous reset in the middle of a two-pass job.
      num_passes = PW'(2);
      data_out_ready = 1'b1;
      acc = 0;
      for (int k = 0; k < 40 && acc < 2; k++) begin
         start = (k == 0);
         @(negedge clk);
         if (data_out_valid && data_out_ready) acc++;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check("pre_reset_beats", acc, 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_valid", data_out_valid, 0);
      check("post_rst_busy",  busy, 0);
      check("post_rst_ce",    rom_ce, 0);
      check("post_rst_addr",  rom_addr, 0);
      @(posedge clk);
      #1;
      run_job(1, 0, -1);

`ifdef WEIGHT_STREAM_ABORT_EN
      num_passes = PW'(2);
      acc = 0;
      for (int k = 0; k < 40 && acc < 2; k++) begin
         start = (k == 0);
         @(negedge clk);
         if (data_out_valid && data_out_ready) acc++;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check("pre_abort_beats", acc, 2);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("abort_valid", data_out_valid, 0);
         check("abort_busy",  busy, 0);
         check("abort_done",  done, 0);
         @(posedge clk);
         #1;
      end
      run_job(1, 0, -1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/weight_rom_stream_ctrl.md
Name: weight_rom_stream_ctrl

Overview:
Sequencer that drives a parameter weight ROM (2-cycle registered read, ce-gated pipeline) and converts it into a proper valid/ready stream for the linear/matmul datapath. It replaces the free-running counter with always-high valid by issuing addresses only when downstream space is guaranteed. It supports N repeated passes over the ROM, one per input row, and start/busy/done control from the layer scheduler.

Parameters:
DEPTH, 32, number of ROM words per pass (tensor size / parallelism)
DATA_WIDTH, 16, bits per ROM word (precision × parallelism, flattened)
ADDR_WIDTH, $clog2(DEPTH)+1, ROM address width, matching the ROM wrapper
ROM_LATENCY, 2, ROM read latency in cycles with ce=1
FIFO_DEPTH, 4, output buffer entries; must be ≥ ROM_LATENCY+2 for 1 beat/cycle
PASS_WIDTH, 16, width of the pass-count input

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin a job; sampled only in IDLE
num_passes  in  PASS_WIDTH  passes over ROM; latched on start; 0 is treated as 1
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse after the final beat is accepted
rom_addr  out  ADDR_WIDTH  ROM read address
rom_ce  out  1  ROM pipeline enable
rom_q  in  DATA_WIDTH  ROM read data
data_out  out  DATA_WIDTH  weight word
data_out_last  out  1  high on the beat from address DEPTH-1 (end of pass)
data_out_valid  out  1  stream valid
data_out_ready  in  1  stream ready

Behaviour:
- Reset is synchronous, active-high (rst); clock clk. On reset: state IDLE, busy=0, done=0, data_out_valid=0, data_out_last=0, rom_ce=0, rom_addr=0. FIFO is emptied, in-flight tracker cleared, address and pass counters are 0.
- Reset mid-job aborts immediately. ROM data still in flight is discarded because the tracker is cleared.
- FSM IDLE→RUN: on start in IDLE. Latch passes = max(num_passes,1), addr=0, pass=0.
- FSM RUN→DRAIN: in the cycle the last address of the last pass is issued.
- FSM DRAIN→IDLE: when in-flight=0, FIFO empty, and no output beat pending. done=1 for that one cycle.
- start in RUN/DRAIN is ignored. start in the same cycle done is pulsed is ignored.
- rom_ce = (state != IDLE). ROM pipeline advances every busy cycle.
- Issue rule (RUN): issue when fifo_count + inflight_count < FIFO_DEPTH, using registered counts; a same-cycle pop gives no credit.
- Issue action: rom_addr = addr. Push tag {valid=1, last=(addr==DEPTH-1)} into a ROM_LATENCY-deep shift register. When not issuing, push valid=0.
- On each issue: addr increments. At DEPTH-1, addr wraps to 0 and pass increments.
- When the shift-register tail is valid, rom_q and the last tag are written to the FIFO.
- FIFO is show-ahead: data_out/data_out_last/data_out_valid reflect the head. A pop happens when valid&&ready.
- Simultaneous push and pop keeps count unchanged. The FIFO never overflows (credit rule guarantees this); overflow is an assertion error.
- Latency: first data_out_valid occurs exactly ROM_LATENCY+2 cycles after the cycle start is sampled.
- Throughput: with ready held high, 1 beat/cycle sustained.
- data_out/data_out_last are stable while valid&&!ready.
- Total beats per job = passes×DEPTH, in address order 0..DEPTH-1 repeated.

Optional Feature:
WEIGHT_STREAM_ABORT_EN.
- Defined: adds input abort (1 bit). abort in RUN/DRAIN clears FIFO, tracker and counters, drops valid next cycle, and returns to IDLE with no done pulse. abort in IDLE has no effect. abort has priority over start.
- Undefined: no port; jobs run to completion or reset.

Decomposition:
- Package weight_stream_pkg: state enum (IDLE, RUN, DRAIN) and tag struct {valid, last}.
- One sub-module weight_stream_fifo: show-ahead, parameterised width/depth, with count output. It stores {last, data}.
- The controller holds FSM, counters and the latency tracker.

Test Plan:
- DEPTH=4, ROM[i]=0x1000+i, num_passes=1, ready=1: start at cycle 0 → valid from cycle 4; beats 0x1000..0x1003; last on 0x1003; done at cycle 8; busy 1..8.
- num_passes=3, ready=1: 12 consecutive beats 0x1000..0x1003 ×3; last on beats 4, 8, 12; no bubbles after first valid.
- num_passes=2, ready random 50%: same 8-beat sequence with no loss or duplication; data stable while stalled; FIFO count never >4.
- ready=0 for 20 cycles after start: exactly 4 words buffered, issue stops (in-flight+count=4); after release, 4 beats drain and the stream continues in order.
- num_passes=0: behaves as 1 pass (4 beats, one done). start pulsed mid-job is ignored.
- rst asserted after beat 2 of a 2-pass job: next cycle valid=0, busy=0; new start yields 0x1000 first. With WEIGHT_STREAM_ABORT_EN, abort mid-pass gives same result with no done.
